// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives every datapath
// enable and mux select, waits on the data-memory handshake with a timeout,
// and counts retired instructions.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dm_ready,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ir_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             dm_re,
    output logic             dm_we,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             err
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StErr    = 3'd7
    } state_e;

    // Opcode / funct encodings
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;
    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSubu  = 6'h23;

    // Mux select encodings
    localparam logic [1:0] PcSeq    = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;
    localparam logic [1:0] PcReg    = 2'b11;
    localparam logic [1:0] DstRd    = 2'b00;
    localparam logic [1:0] DstRt    = 2'b01;
    localparam logic [1:0] DstRa    = 2'b10;
    localparam logic [1:0] WbAlu    = 2'b00;
    localparam logic [1:0] WbMem    = 2'b01;
    localparam logic [1:0] WbPc     = 2'b10;

    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

    state_e           r_state;
    state_e           w_state_d;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_d;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             r_err;

    logic w_is_rtype;
    logic w_is_alu_r;
    logic w_is_imm;
    logic w_is_jr;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_mem;
    logic w_is_alu;

    // Instruction class decode from the IR fields
    always_comb begin
        w_is_rtype = (opcode == OpRtype);
        w_is_alu_r = w_is_rtype && ((funct == FnAddu) || (funct == FnSubu));
        w_is_jr    = w_is_rtype && (funct == FnJr);
        w_is_imm   = (opcode == OpOri) || (opcode == OpLui);
        w_is_lw    = (opcode == OpLw);
        w_is_sw    = (opcode == OpSw);
        w_is_mem   = w_is_lw || w_is_sw;
        w_is_alu   = w_is_alu_r || w_is_imm;
    end

    // State, wait counter, retire counter and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StFetch;
            r_wait_cnt  <= 8'd0;
            r_instr_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
            if (instr_done) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
            if (w_state_d == StErr) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        pc_we        = 1'b0;
        pc_sel       = PcSeq;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = DstRd;
        wb_sel       = WbAlu;
        dm_re        = 1'b0;
        dm_we        = 1'b0;
        instr_done   = 1'b0;

        case (r_state)
            StFetch: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                pc_sel    = PcSeq;
                w_state_d = StDecode;
            end

            StDecode: begin
                w_state_d = StExec;
            end

            StExec: begin
                if (w_is_alu) begin
                    w_state_d = StWb;
                end else if (w_is_mem) begin
                    w_state_d    = StMem;
                    w_wait_cnt_d = 8'd0;
                end else begin
                    // Control-flow ops and unknown encodings retire here
                    w_state_d  = StFetch;
                    instr_done = 1'b1;
                    if (opcode == OpBeq) begin
                        pc_sel = PcBranch;
                        pc_we  = zero;
                    end else if (opcode == OpJ) begin
                        pc_sel = PcJump;
                        pc_we  = 1'b1;
                    end else if (opcode == OpJal) begin
                        pc_sel  = PcJump;
                        pc_we   = 1'b1;
                        reg_we  = 1'b1;
                        reg_dst = DstRa;
                        wb_sel  = WbPc;
                    end else if (w_is_jr) begin
                        pc_sel = PcReg;
                        pc_we  = 1'b1;
                    end
                end
            end

            StMem: begin
                dm_re = w_is_lw;
                dm_we = w_is_sw;
                if (!w_is_mem) begin
                    // IR changed under us; nothing to wait for
                    w_state_d  = StFetch;
                    instr_done = 1'b1;
                end else if (dm_ready) begin
                    if (w_is_lw) begin
                        w_state_d = StWb;
                    end else begin
                        w_state_d  = StFetch;
                        instr_done = 1'b1;
                    end
                end else if (r_wait_cnt == TimeoutVal) begin
                    w_state_d = StErr;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + 8'd1;
                end
            end

            StWb: begin
                reg_we     = 1'b1;
                w_state_d  = StFetch;
                instr_done = 1'b1;
                if (w_is_lw) begin
                    reg_dst = DstRt;
                    wb_sel  = WbMem;
                end else if (w_is_imm) begin
                    reg_dst = DstRt;
                    wb_sel  = WbAlu;
                end else begin
                    reg_dst = DstRd;
                    wb_sel  = WbAlu;
                end
            end

            StErr: begin
                w_state_d = StErr;
            end

            default: begin
                // Unused encodings fall back to a fresh fetch
                w_state_d = StFetch;
            end
        endcase
    end

    // Registered status outputs
    always_comb begin
        state     = r_state;
        instr_cnt = r_instr_cnt;
        err       = r_err;
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized bench for mc_ctrl_fsm against a per-instruction
// cycle-sequence model, plus directed literal expectations.
module tb_mc_ctrl_fsm;

    localparam int unsigned TO = 15;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic          zero;
    logic          dm_ready;
    logic          pc_we;
    logic [1:0]    pc_sel;
    logic          ir_we;
    logic          reg_we;
    logic [1:0]    reg_dst;
    logic [1:0]    wb_sel;
    logic          dm_re;
    logic          dm_we;
    logic [2:0]    state;
    logic          instr_done;
    logic [CW-1:0] instr_cnt;
    logic          err;

    mc_ctrl_fsm #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .dm_ready  (dm_ready),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wb_sel    (wb_sel),
        .dm_re     (dm_re),
        .dm_we     (dm_we),
        .state     (state),
        .instr_done(instr_done),
        .instr_cnt (instr_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected cycle: inputs to drive plus required outputs
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        logic [2:0] st;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       dm_re;
        logic       dm_we;
        logic       done;
        logic       err;
    } rec_t;

    rec_t          plan[$];
    rec_t          exp_r;
    logic [CW-1:0] exp_cnt;
    logic [CW-1:0] m_cnt;
    bit            chk_en;
    int            n_checks;
    int            n_pass;

    logic [2:0] obs_st    [64];
    logic       obs_pcwe  [64];
    logic [1:0] obs_pcsel [64];
    logic       obs_regwe [64];
    logic [1:0] obs_regdst[64];
    logic [1:0] obs_wbsel [64];
    logic       obs_dmre  [64];
    logic       obs_done  [64];
    logic       obs_err   [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic rec_t blank(input logic [2:0] st, input logic [5:0] op,
                                   input logic [5:0] fn);
        rec_t r;
        r.rst     = 1'b0;
        r.op      = op;
        r.fn      = fn;
        r.z       = 1'($urandom);
        r.rdy     = 1'($urandom);
        r.st      = st;
        r.pc_we   = 1'b0;
        r.pc_sel  = 2'd0;
        r.ir_we   = 1'b0;
        r.reg_we  = 1'b0;
        r.reg_dst = 2'd0;
        r.wb_sel  = 2'd0;
        r.dm_re   = 1'b0;
        r.dm_we   = 1'b0;
        r.done    = 1'b0;
        r.err     = 1'b0;
        return r;
    endfunction

    task automatic push_reset();
        rec_t r;
        r       = blank(3'd0, 6'($urandom), 6'($urandom));
        r.rst   = 1'b1;
        r.pc_we = 1'b1;
        r.ir_we = 1'b1;
        plan.push_back(r);
    endtask

    // Expected cycle sequence of one instruction. delay = MEM cycles without
    // dm_ready before it arrives; delay > TO means it never arrives.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int delay, input int err_cycles);
        rec_t r;
        bit   is_alu;
        bit   is_lw;
        bit   is_mem;
        is_alu = (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) || op == 6'h0d || op == 6'h0f;
        is_lw  = (op == 6'h23);
        is_mem = is_lw || (op == 6'h2b);

        r       = blank(3'd0, 6'($urandom), 6'($urandom));
        r.pc_we = 1'b1;
        r.ir_we = 1'b1;
        plan.push_back(r);

        r = blank(3'd1, op, fn);
        plan.push_back(r);

        r   = blank(3'd2, op, fn);
        r.z = z;
        if (!is_alu && !is_mem) begin
            r.done = 1'b1;
            if (op == 6'h04) begin
                r.pc_sel = 2'd1;
                r.pc_we  = z;
            end else if (op == 6'h02) begin
                r.pc_sel = 2'd2;
                r.pc_we  = 1'b1;
            end else if (op == 6'h03) begin
                r.pc_sel  = 2'd2;
                r.pc_we   = 1'b1;
                r.reg_we  = 1'b1;
                r.reg_dst = 2'd2;
                r.wb_sel  = 2'd2;
            end else if (op == 6'h00 && fn == 6'h08) begin
                r.pc_sel = 2'd3;
                r.pc_we  = 1'b1;
            end
        end
        plan.push_back(r);

        if (is_mem) begin
            for (int k = 0; k <= int'(TO); k++) begin
                r       = blank(3'd3, op, fn);
                r.rdy   = (k >= delay);
                r.dm_re = is_lw;
                r.dm_we = !is_lw;
                r.done  = r.rdy && !is_lw;
                plan.push_back(r);
                if (r.rdy) break;
            end
            if (delay > int'(TO)) begin
                for (int e = 0; e < err_cycles; e++) begin
                    r     = blank(3'd7, op, fn);
                    r.err = 1'b1;
                    plan.push_back(r);
                end
            end
        end

        if (is_alu || (is_lw && delay <= int'(TO))) begin
            r        = blank(3'd4, op, fn);
            r.reg_we = 1'b1;
            r.done   = 1'b1;
            if (op != 6'h00) r.reg_dst = 2'd1;
            if (is_lw) r.wb_sel = 2'd1;
            plan.push_back(r);
        end
    endtask

    // Drive the queued cycles; count non-reset, non-ERR cycles
    task automatic run_plan(input int first_cnt_lit, output int ncyc);
        rec_t r;
        int   nobs;
        ncyc = 0;
        nobs = 0;
        while (plan.size() > 0) begin
            r = plan.pop_front();
            @(posedge clk);
            #1;
            reset    = r.rst;
            opcode   = r.op;
            funct    = r.fn;
            zero     = r.z;
            dm_ready = r.rdy;
            if (r.rst) m_cnt = '0;
            exp_r   = r;
            exp_cnt = m_cnt;
            chk_en  = 1'b1;
            if (r.done) m_cnt = m_cnt + 1'b1;
            #1;
            if (nobs < 64) begin
                obs_st[nobs]     = state;
                obs_pcwe[nobs]   = pc_we;
                obs_pcsel[nobs]  = pc_sel;
                obs_regwe[nobs]  = reg_we;
                obs_regdst[nobs] = reg_dst;
                obs_wbsel[nobs]  = wb_sel;
                obs_dmre[nobs]   = dm_re;
                obs_done[nobs]   = instr_done;
                obs_err[nobs]    = err;
            end
            if (nobs == 0 && first_cnt_lit >= 0) begin
                check("cnt_at_start", 32'(instr_cnt), 32'(first_cnt_lit));
            end
            nobs++;
            if (!r.rst && r.st != 3'd7) ncyc++;
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state), 32'(exp_r.st));
            check("pc_we", 32'(pc_we), 32'(exp_r.pc_we));
            check("pc_sel", 32'(pc_sel), 32'(exp_r.pc_sel));
            check("ir_we", 32'(ir_we), 32'(exp_r.ir_we));
            check("reg_we", 32'(reg_we), 32'(exp_r.reg_we));
            check("reg_dst", 32'(reg_dst), 32'(exp_r.reg_dst));
            check("wb_sel", 32'(wb_sel), 32'(exp_r.wb_sel));
            check("dm_re", 32'(dm_re), 32'(exp_r.dm_re));
            check("dm_we", 32'(dm_we), 32'(exp_r.dm_we));
            check("instr_done", 32'(instr_done), 32'(exp_r.done));
            check("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
            check("err", 32'(err), 32'(exp_r.err));
        end
    end

    initial begin
        int n;
        reset    = 1'b1;
        opcode   = 6'd0;
        funct    = 6'd0;
        zero     = 1'b0;
        dm_ready = 1'b0;
        m_cnt    = '0;
        chk_en   = 1'b0;
        n_checks = 0;
        n_pass   = 0;

        push_reset();
        run_plan(0, n);
        check("rst_state", 32'(obs_st[0]), 32'd0);
        check("rst_pc_we", 32'(obs_pcwe[0]), 32'd1);
        check("rst_err", 32'(obs_err[0]), 32'd0);

        // addu: 0,1,2,4 then retire
        build(6'h00, 6'h21, 1'b0, 0, 0);
        run_plan(-1, n);
        check("addu_cycles", 32'(n), 32'd4);
        check("addu_st1", 32'(obs_st[1]), 32'd1);
        check("addu_st2", 32'(obs_st[2]), 32'd2);
        check("addu_st3", 32'(obs_st[3]), 32'd4);
        check("addu_regwe_exec", 32'(obs_regwe[2]), 32'd0);
        check("addu_regwe_wb", 32'(obs_regwe[3]), 32'd1);
        check("addu_done", 32'(obs_done[3]), 32'd1);

        build(6'h04, 6'h00, 1'b1, 0, 0);
        run_plan(1, n);
        check("beq_t_cycles", 32'(n), 32'd3);
        check("beq_t_pcwe", 32'(obs_pcwe[2]), 32'd1);
        check("beq_t_pcsel", 32'(obs_pcsel[2]), 32'd1);

        build(6'h04, 6'h00, 1'b0, 0, 0);
        run_plan(2, n);
        check("beq_nt_cycles", 32'(n), 32'd3);
        check("beq_nt_pcwe", 32'(obs_pcwe[2]), 32'd0);

        build(6'h23, 6'h00, 1'b0, 3, 0);
        run_plan(3, n);
        check("lw_cycles", 32'(n), 32'd8);
        for (int i = 3; i < 7; i++) check("lw_dm_re_held", 32'(obs_dmre[i]), 32'd1);
        check("lw_wb_sel", 32'(obs_wbsel[7]), 32'd1);
        check("lw_reg_dst", 32'(obs_regdst[7]), 32'd1);

        build(6'h03, 6'h00, 1'b0, 0, 0);
        run_plan(4, n);
        check("jal_cycles", 32'(n), 32'd3);
        check("jal_pcsel", 32'(obs_pcsel[2]), 32'd2);
        check("jal_regwe", 32'(obs_regwe[2]), 32'd1);
        check("jal_regdst", 32'(obs_regdst[2]), 32'd2);
        check("jal_wbsel", 32'(obs_wbsel[2]), 32'd2);

        build(6'h3f, 6'h00, 1'b0, 0, 0);
        run_plan(5, n);
        check("nop_cycles", 32'(n), 32'd3);

        for (int i = 0; i < 9; i++) begin
            build(6'h02, 6'($urandom), 1'b0, 0, 0);
            run_plan(6 + i, n);
        end
        build(6'h00, 6'h23, 1'b0, 0, 0);
        run_plan(15, n);
        // 16 retired: counter has wrapped
        build(6'h3f, 6'h00, 1'b0, 0, 0);
        run_plan(0, n);

        // sw with no dm_ready: 16 MEM cycles then ERR
        build(6'h2b, 6'h00, 1'b0, 99, 3);
        run_plan(1, n);
        check("sw_to_cycles", 32'(n), 32'd19);
        check("sw_pre_err", 32'(obs_err[18]), 32'd0);
        check("sw_err_state", 32'(obs_st[19]), 32'd7);
        check("sw_err_flag", 32'(obs_err[19]), 32'd1);
        check("sw_err_pcwe", 32'(obs_pcwe[21]), 32'd0);
        push_reset();
        run_plan(0, n);
        check("err_cleared", 32'(obs_err[0]), 32'd0);
        check("err_rst_state", 32'(obs_st[0]), 32'd0);

        // Reset lands in the second MEM cycle of a lw
        build(6'h23, 6'h00, 1'b0, 5, 0);
        while (plan.size() > 5) void'(plan.pop_back());
        run_plan(0, n);
        #6;
        reset = 1'b1;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_done", 32'(instr_done), 32'd0);
        check("midrst_cnt", 32'(instr_cnt), 32'd0);
        push_reset();
        run_plan(0, n);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         sel;
            int         dly;
            sel = int'($urandom_range(0, 11));
            op  = 6'h00;
            fn  = 6'($urandom);
            case (sel)
                0: fn = 6'h21;
                1: fn = 6'h23;
                2: fn = 6'h08;
                3: op = 6'h00;
                4: op = 6'h0d;
                5: op = 6'h0f;
                6: op = 6'h23;
                7: op = 6'h2b;
                8: op = 6'h04;
                9: op = 6'h02;
                10: op = 6'h03;
                default: op = 6'($urandom);
            endcase
            dly = ($urandom_range(0, 9) == 0) ? int'(TO) + 1 : int'($urandom_range(0, 5));
            build(op, fn, 1'($urandom), dly, int'($urandom_range(1, 3)));
            if (plan[$].st == 3'd7) push_reset();
            run_plan(-1, n);
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
